branch_ctrl: RTL and testbench

- Branch resolution block that drives the PC's branch/target inputs. It is the producer side of the PC redirect interface.
- Takes the decoded branch op, the latched ALU flags and the current progCtr. Produces the 1-bit branch request and the 8-bit target that the PC samples on the next clk edge.
- Jump targets come from a software-loaded 16-entry target LUT.
- An optional return-address stack (RAS) provides call/return.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_ctrl_ret_stack.sv | 72 +++++++
 rtl/branch_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and widths for the branch resolution slice.
// Holds the br_op_t encoding, PC/LUT-index widths and the default RAS depth.
package branch_pkg;

  localparam int PC_WIDTH      = 8;
  localparam int LUT_AW        = 4;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JMP  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BLT  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } br_op_t;

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// ret_stack: circular return-address LIFO (push/pop, top, full/empty, err).
// Ports: clk, reset, push, pop, push_data -> top, full, empty, err (sticky).
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [PW-1:0] ptr_nxt, ptr_prv;

  // ptr_q is the next free slot; top sits one below it (mod DEPTH)
  assign ptr_nxt = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_prv = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = mem_q[ptr_prv];
  assign err   = err_q;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      // a full stack overwrites its oldest entry
      mem_d[ptr_q] = push_data;
      ptr_d = ptr_nxt;
      if (full) err_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_prv;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branch ops into a same-cycle PC redirect.
// In: clk, reset, instr_valid, br_op, lut_idx, progCtr, flag_we, alu_zero,
// alu_neg, lut_we/waddr/wdata. Out: branch, target, ras_err.
// Optional RET_STACK_EN compiles in the return-address stack (CALL/RET).
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W      = PC_WIDTH,
  parameter int LUT_DEPTH = 16,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [2:0]        br_op,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic [PC_W-1:0]   progCtr,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic              branch,
  output logic [PC_W-1:0]   target,
  output logic              ras_err
);

  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_d [LUT_DEPTH];
  logic            z_q, z_d;
  logic            n_q, n_d;
  logic [PC_W-1:0] lut_rd;
  logic            take, is_ret, push, pop;
  logic            ras_empty;
  logic [PC_W-1:0] ras_top;

  // indices at or above LUT_DEPTH match nothing and read 0
  always_comb begin
    lut_rd = '0;
    for (int i = 0; i < LUT_DEPTH; i++)
      if (lut_idx == LUT_AW'(i)) lut_rd = lut_q[i];
  end

  always_comb begin
    lut_d = lut_q;
    for (int i = 0; i < LUT_DEPTH; i++)
      if (lut_we && lut_waddr == LUT_AW'(i)) lut_d[i] = lut_wdata;
  end

  assign z_d = flag_we ? alu_zero : z_q;
  assign n_d = flag_we ? alu_neg  : n_q;

  always_comb begin
    take   = 1'b0;
    is_ret = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    if (instr_valid) begin
      unique case (br_op_t'(br_op))
        OP_JMP:  take = 1'b1;
        OP_BEQ:  take = z_q;
        OP_BNE:  take = ~z_q;
        OP_BLT:  take = n_q;
        OP_CALL: begin
          take = 1'b1;
          push = 1'b1;
        end
        OP_RET: begin
          is_ret = 1'b1;
          pop    = 1'b1;
          take   = ~ras_empty;
        end
        default: take = 1'b0;
      endcase
    end
  end

  assign branch = take & ~reset;
  assign target = branch ? (is_ret ? ras_top : lut_rd) : '0;

`ifdef RET_STACK_EN
  logic ras_full;

  ret_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(progCtr + PC_W'(1)),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty),
    .err      (ras_err)
  );

  logic unused_ras;
  assign unused_ras = ras_full;
`else
  // no stack: RET never taken, CALL degenerates to JMP
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
  assign ras_err   = 1'b0;

  logic unused_ras;
  assign unused_ras = push ^ pop ^ (^progCtr);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_q <= '{default: '0};
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      lut_q <= lut_d;
      z_q   <= z_d;
      n_q   <= n_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed checks of branch_ctrl with hand-computed values.
// Expectations follow RET_STACK_EN when the bench is built with it.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [2:0] br_op;
  logic [3:0] lut_idx;
  logic [7:0] progCtr;
  logic       flag_we, alu_zero, alu_neg;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [7:0] lut_wdata;
  logic       branch;
  logic [7:0] target;
  logic       ras_err;

  int n_chk  = 0;
  int n_pass = 0;

  branch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .br_op      (br_op),
    .lut_idx    (lut_idx),
    .progCtr    (progCtr),
    .flag_we    (flag_we),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .branch     (branch),
    .target     (target),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance past the next rising edge; inputs then change safely
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    br_op       = OP_NONE;
    flag_we     = 1'b0;
    lut_we      = 1'b0;
  endtask

  task automatic op(logic [2:0] o, logic [3:0] idx, logic [7:0] pc);
    instr_valid = 1'b1;
    br_op       = o;
    lut_idx     = idx;
    progCtr     = pc;
    #1;
  endtask

  task automatic lut_wr(logic [3:0] a, logic [7:0] d);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = d;
    step();
    lut_we = 1'b0;
  endtask

  task automatic set_flags(logic z, logic n);
    flag_we  = 1'b1;
    alu_zero = z;
    alu_neg  = n;
    step();
    flag_we = 1'b0;
  endtask

  task automatic br(string tag, logic b, logic [7:0] t);
    chk({tag, ".br"}, 32'(branch), 32'(b));
    chk({tag, ".tg"}, 32'(target), 32'(t));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

`ifdef RET_STACK_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  initial begin
    reset = 1'b1;
    idle();
    lut_idx = '0;
    progCtr = '0;
    alu_zero = 1'b0;
    alu_neg  = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    step();
    // branch forced low while reset is high, even for JMP
    op(OP_JMP, 4'd0, 8'd0);
    br("rst_jmp", 1'b0, 8'd0);
    chk("rst_err", 32'(ras_err), 32'd0);
    idle();
    reset = 1'b0;
    step();

    lut_wr(4'd3, 8'd45);
    op(OP_JMP, 4'd3, 8'd0);
    br("jmp", 1'b1, 8'd45);
    idle();
    #1;
    br("inval", 1'b0, 8'd0);

    // same-cycle write returns the old entry
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 8'd99;
    op(OP_JMP, 4'd3, 8'd0);
    br("lut_old", 1'b1, 8'd45);
    step();
    lut_we = 1'b0;
    #1;
    br("lut_new", 1'b1, 8'd99);
    idle();
    lut_wr(4'd3, 8'd45);

    set_flags(1'b1, 1'b0);
    op(OP_BEQ, 4'd3, 8'd0);
    br("beq_z1", 1'b1, 8'd45);
    op(OP_BNE, 4'd3, 8'd0);
    br("bne_z1", 1'b0, 8'd0);
    // flags written this cycle are not seen yet
    flag_we = 1'b1; alu_zero = 1'b0; alu_neg = 1'b1;
    op(OP_BEQ, 4'd3, 8'd0);
    br("beq_old", 1'b1, 8'd45);
    step();
    flag_we = 1'b0;
    op(OP_BEQ, 4'd3, 8'd0);
    br("beq_z0", 1'b0, 8'd0);
    op(OP_BNE, 4'd3, 8'd0);
    br("bne_z0", 1'b1, 8'd45);
    op(OP_BLT, 4'd3, 8'd0);
    br("blt_n1", 1'b1, 8'd45);
    op(3'd7, 4'd3, 8'd0);
    br("rsvd", 1'b0, 8'd0);
    idle();
    set_flags(1'b0, 1'b0);
    op(OP_BLT, 4'd3, 8'd0);
    br("blt_n0", 1'b0, 8'd0);
    idle();

    // CALL / RET / underflow
    lut_wr(4'd5, 8'd127);
    op(OP_CALL, 4'd5, 8'd20);
    br("call", 1'b1, 8'd127);
    step();
    op(OP_RET, 4'd0, 8'd40);
    br("ret", RAS, RAS ? 8'd21 : 8'd0);
    step();
    op(OP_RET, 4'd0, 8'd41);
    br("ret_empty", 1'b0, 8'd0);
    step();
    idle();
    #1;
    chk("uf_err", 32'(ras_err), 32'(RAS));

    do_reset();
    chk("err_clr", 32'(ras_err), 32'd0);
    lut_wr(4'd5, 8'd127);

    // overflow: five calls into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      op(OP_CALL, 4'd5, 8'(10 + i));
      step();
    end
    idle();
    #1;
    chk("of_err", 32'(ras_err), 32'(RAS));
    for (int i = 0; i < 4; i++) begin
      op(OP_RET, 4'd0, 8'd0);
      br($sformatf("of_ret%0d", i), RAS, RAS ? 8'(15 - i) : 8'd0);
      step();
    end
    op(OP_RET, 4'd0, 8'd0);
    br("of_ret_end", 1'b0, 8'd0);
    idle();

    // return address wraps at PC_W bits
    op(OP_CALL, 4'd5, 8'd255);
    step();
    op(OP_RET, 4'd0, 8'd7);
    br("wrap", RAS, 8'd0);
    step();
    idle();

    // reset mid-sequence with two entries and Z set
    set_flags(1'b1, 1'b0);
    op(OP_CALL, 4'd5, 8'd30);
    step();
    op(OP_CALL, 4'd5, 8'd31);
    step();
    op(OP_RET, 4'd0, 8'd0);
    br("pre_rst", RAS, RAS ? 8'd32 : 8'd0);
    reset = 1'b1;
    #1;
    br("mid_rst", 1'b0, 8'd0);
    step();
    reset = 1'b0;
    #1;
    op(OP_RET, 4'd0, 8'd0);
    br("rst_ret", 1'b0, 8'd0);
    op(OP_BEQ, 4'd3, 8'd0);
    br("rst_beq", 1'b0, 8'd0);
    op(OP_JMP, 4'd3, 8'd0);
    br("rst_lut", 1'b1, 8'd0);
    chk("rst_err2", 32'(ras_err), 32'd0);
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
